// File: rtl/uart_tx_if.sv
// Byte handshake between the core and the UART transmitter.
interface uart_tx_if;
    logic       tx_byte_vld;
    logic [7:0] tx_byte;
    logic       tx_byte_rdy;

    modport master (output tx_byte_vld, output tx_byte, input tx_byte_rdy);
    modport slave  (input tx_byte_vld, input tx_byte, output tx_byte_rdy);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-entry holding register so that
// consecutive frames leave the line with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    uart_tx_if.slave   bus,
    output logic       o_tx,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic             hold_full_q;
    logic             tx_q;
    logic             done_q;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       shift_q, shift_d;

    logic rdy;
    logic accept;
    logic bit_end;
    logic load_shift;

    assign rdy        = !hold_full_q && !i_rst;
    assign accept     = bus.tx_byte_vld && rdy;
    assign bit_end    = (cnt_q == CNT_LAST);
    assign load_shift = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    assign hold_d  = accept ? bus.tx_byte : hold_q;
    assign shift_d = load_shift ? hold_q : shift_q;

    assign bus.tx_byte_rdy = rdy;
    assign o_tx            = tx_q;
    assign o_tx_done       = done_q;
    assign o_tx_active     = state_q inside {START, DATA, STOP};

    // Byte storage carries no reset; hold_full_q alone says whether hold_q is meaningful.
    always_ff @(posedge i_clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                hold_full_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    tx_q  <= 1'b1;
                    if (hold_full_q) begin
                        hold_full_q <= 1'b0;
                        tx_q        <= 1'b0;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            idx_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shift_q[idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Registered one clock early so the pulse covers the last stop clock.
                    if (cnt_q == CNT_DONE) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (hold_full_q) begin
                            hold_full_q <= 1'b0;
                            tx_q        <= 1'b0;
                            state_q     <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
